// File: rtl/timer_bank.sv
// Bank of N_TIMERS memory-mapped auto-reload timers with W1C interrupt flags and a summary STATUS register.
// Optional shared prescaler is built only when TIMER_BANK_PRESCALER_EN is defined.
module timer_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          N_TIMERS  = 4,
    parameter int          WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam logic [31:0] CH_SPAN = 32'(16 * N_TIMERS);

    logic [31:0]         off;
    logic                aligned;
    logic                ch_hit;
    logic                status_hit;
    logic                pre_hit;
    logic [2:0]          ch_sel;
    logic [1:0]          reg_sel;
    logic                tick;

    logic [WIDTH-1:0]    th [N_TIMERS];
    logic [WIDTH-1:0]    tl [N_TIMERS];
    logic [N_TIMERS-1:0] en, ie, pend, os;
    logic [N_TIMERS-1:0] wr_th, wr_tl, wr_tcon, ovf, clr;

    // Upper wdata bits are legitimately ignored for narrow counters.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign off        = addr - BASE_ADDR;
    assign aligned    = (addr[1:0] == 2'b00);
    assign ch_hit     = aligned && (off < CH_SPAN);
    assign status_hit = aligned && (off == CH_SPAN);
    assign pre_hit    = aligned && (off == CH_SPAN + 32'd4);
    assign ch_sel     = off[6:4];
    assign reg_sel    = off[3:2];

`ifdef TIMER_BANK_PRESCALER_EN
    logic [15:0] prescale;
    logic [15:0] pcnt;

    assign tick = (pcnt == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            pcnt     <= '0;
        end else if (wr && pre_hit) begin
            prescale <= wdata[15:0];
            pcnt     <= '0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        wr_th   = '0;
        wr_tl   = '0;
        wr_tcon = '0;
        ovf     = '0;
        clr     = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            wr_th[i]   = wr && ch_hit && (ch_sel == 3'(i)) && (reg_sel == 2'd0);
            wr_tl[i]   = wr && ch_hit && (ch_sel == 3'(i)) && (reg_sel == 2'd1);
            wr_tcon[i] = wr && ch_hit && (ch_sel == 3'(i)) && (reg_sel == 2'd2);
            ovf[i]     = tick && en[i] && (tl[i] == '1);
            clr[i]     = (wr_tcon[i] && wdata[2]) || (wr && status_hit && wdata[i]);
        end
    end

    // Overflow set is OR'd after the clear so a same-edge W1C never drops an interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                th[i] <= '0;
                tl[i] <= '0;
            end
            en   <= '0;
            ie   <= '0;
            pend <= '0;
            os   <= '0;
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr_th[i])
                    th[i] <= wdata[WIDTH-1:0];
                if (wr_tl[i])
                    tl[i] <= wdata[WIDTH-1:0];
                else if (tick && en[i])
                    tl[i] <= ovf[i] ? th[i] : tl[i] + WIDTH'(1);
                if (wr_tcon[i]) begin
                    en[i] <= wdata[0];
                    ie[i] <= wdata[1];
                    os[i] <= wdata[3];
                end else if (ovf[i] && os[i]) begin
                    en[i] <= 1'b0;
                end
                pend[i] <= (ovf[i] && ie[i]) || (pend[i] && !clr[i]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (ch_hit) begin
                for (int i = 0; i < N_TIMERS; i++) begin
                    if (ch_sel == 3'(i)) begin
                        case (reg_sel)
                            2'd0:    rdata = 32'(th[i]);
                            2'd1:    rdata = 32'(tl[i]);
                            2'd2:    rdata = {28'd0, os[i], pend[i], ie[i], en[i]};
                            default: rdata = '0;
                        endcase
                    end
                end
            end else if (status_hit) begin
                rdata = 32'(pend);
            end
`ifdef TIMER_BANK_PRESCALER_EN
            else if (pre_hit) begin
                rdata = 32'(prescale);
            end
`endif
        end
    end

    assign irqout = |(pend & ie);

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a 4x32 bank (main) and a 2x8 bank (width/decode).
// Directed reads push expectations; a negedge monitor pops and compares.
module tb_timer_bank;

    localparam logic [31:0] B0 = 32'h40000000;
    localparam logic [31:0] B1 = 32'h50000000;
    localparam logic [31:0] G0 = B0 + 32'h40;
    localparam logic [31:0] G1 = B1 + 32'h20;

    typedef struct {
        logic [31:0] data;
        bit          dut1;
        int          irq;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd0, wr0, rd1, wr1, probe;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] act;
    logic        act_irq;

    always #5 clk = ~clk;

    timer_bank #(.BASE_ADDR(B0)) u0 (
        .clk(clk), .reset(reset), .rd(rd0), .wr(wr0), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .irqout(irq0)
    );

    timer_bank #(.BASE_ADDR(B1), .N_TIMERS(2), .WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .rd(rd1), .wr(wr1), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .irqout(irq1)
    );

    always @(negedge clk) begin
        if (rd0 || rd1 || probe) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: read seen with no expectation queued");
            end else begin
                e = sb.pop_front();
                act = e.dut1 ? rdata1 : rdata0;
                checks++;
                if (act !== e.data) begin
                    errors++;
                    $display("FAIL %s: rdata got 0x%08h expected 0x%08h", e.name, act, e.data);
                end
                if (e.irq >= 0) begin
                    act_irq = e.dut1 ? irq1 : irq0;
                    checks++;
                    if (act_irq !== e.irq[0]) begin
                        errors++;
                        $display("FAIL %s_irq: irqout got %0b expected %0d", e.name, act_irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic wr_reg(input bit d1, input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        if (d1) wr1 = 1'b1; else wr0 = 1'b1;
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic rd_reg(input bit d1, input logic [31:0] a, input logic [31:0] exp_d,
                          input int exp_irq, input string name);
        exp_t x;
        x.data = exp_d;
        x.dut1 = d1;
        x.irq  = exp_irq;
        x.name = name;
        sb.push_back(x);
        addr = a;
        if (d1) rd1 = 1'b1; else rd0 = 1'b1;
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic probe_idle(input logic [31:0] a, input string name);
        exp_t x;
        x.data = 32'h0;
        x.dut1 = 1'b0;
        x.irq  = -1;
        x.name = name;
        sb.push_back(x);
        addr  = a;
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; probe = 1'b0;
        addr = '0; wdata = '0;
        @(posedge clk);
        #1;

        // Reset values
        rd_reg(0, B0 + 32'h08, 32'h0, 0, "reset_tcon0");
        rd_reg(0, G0,          32'h0, 0, "reset_status");
        rd_reg(0, G0 + 32'h4,  32'h0, 0, "reset_prescale");
        reset = 1'b1;

        // TL write beats a same-edge tick
        wr_reg(0, B0 + 32'h18, 32'h1);
        rd_reg(0, B0 + 32'h14, 32'h0,   -1, "ch1_count0");
        rd_reg(0, B0 + 32'h14, 32'h1,   -1, "ch1_count1");
        wr_reg(0, B0 + 32'h14, 32'h100);
        rd_reg(0, B0 + 32'h14, 32'h100, -1, "tl_write_wins");
        rd_reg(0, B0 + 32'h14, 32'h101, -1, "tl_after_write");
        wr_reg(0, B0 + 32'h18, 32'h0);
        wr_reg(0, B0 + 32'h14, 32'h0);
        rd_reg(0, B0 + 32'h14, 32'h0,   -1, "ch1_cleared");

        // Auto-reload on channel 0
        wr_reg(0, B0 + 32'h00, 32'hFFFFFFFD);
        wr_reg(0, B0 + 32'h04, 32'hFFFFFFFD);
        wr_reg(0, B0 + 32'h08, 32'h3);
        rd_reg(0, B0 + 32'h04, 32'hFFFFFFFD, 0, "ar_tl_fd");
        rd_reg(0, B0 + 32'h04, 32'hFFFFFFFE, 0, "ar_tl_fe");
        rd_reg(0, B0 + 32'h04, 32'hFFFFFFFF, 0, "ar_tl_ff");
        rd_reg(0, B0 + 32'h04, 32'hFFFFFFFD, 1, "ar_reload");
        wr_reg(0, B0 + 32'h08, 32'h7);
        rd_reg(0, B0 + 32'h08, 32'h3, 0, "ar_w1c_tcon");
        wr_reg(0, B0 + 32'h08, 32'h1);
        rd_reg(0, B0 + 32'h08, 32'h5, 0, "mask_keeps_pending");
        wr_reg(0, B0 + 32'h08, 32'h4);
        rd_reg(0, B0 + 32'h08, 32'h0, 0, "ovf_masked_no_set");
        rd_reg(0, B0 + 32'h04, 32'hFFFFFFFD, -1, "ar_tl_held");

        // One-shot on channel 2
        wr_reg(0, B0 + 32'h20, 32'h5);
        wr_reg(0, B0 + 32'h24, 32'hFFFFFFFE);
        wr_reg(0, B0 + 32'h28, 32'hB);
        rd_reg(0, B0 + 32'h24, 32'hFFFFFFFE, -1, "os_tl_fe");
        rd_reg(0, B0 + 32'h24, 32'hFFFFFFFF, -1, "os_tl_ff");
        rd_reg(0, B0 + 32'h24, 32'h5, 1, "os_reload");
        rd_reg(0, B0 + 32'h28, 32'hE, 1, "os_tcon");
        rd_reg(0, B0 + 32'h24, 32'h5, -1, "os_tl_holds");

        // Address decode
        wr_reg(0, B0 + 32'h2C, 32'hFFFFFFFF);
        rd_reg(0, B0 + 32'h2C, 32'h0, -1, "reserved_reads0");
        rd_reg(0, B0 + 32'h22, 32'h0, -1, "misaligned_reads0");
        probe_idle(B0 + 32'h20, "rd_low_reads0");
        rd_reg(0, B0 + 32'h20, 32'h5, -1, "th2_readback");
        rd_reg(0, B0 + 32'h48, 32'h0, -1, "unmapped_reads0");
        wr_reg(0, G0, 32'h4);
        rd_reg(0, G0, 32'h0, 0, "status_w1c_ch2");

        // STATUS summary and clear-vs-overflow race
        wr_reg(0, B0 + 32'h00, 32'h0);
        wr_reg(0, B0 + 32'h04, 32'hFFFFFFFF);
        wr_reg(0, B0 + 32'h08, 32'hB);
        wr_reg(0, B0 + 32'h30, 32'hFFFFFFFC);
        wr_reg(0, B0 + 32'h34, 32'hFFFFFFFE);
        wr_reg(0, B0 + 32'h38, 32'h3);
        rd_reg(0, B0 + 32'h34, 32'hFFFFFFFE, 1, "ch3_start");
        rd_reg(0, G0, 32'h1, 1, "status_ch0");
        rd_reg(0, G0, 32'h9, 1, "status_ch0_ch3");
        wr_reg(0, G0, 32'h1);
        rd_reg(0, G0, 32'h8, 1, "status_clear_ch0");
        wr_reg(0, G0, 32'h8);
        rd_reg(0, G0, 32'h8, 1, "status_race_keeps");
        rd_reg(0, B0 + 32'h34, 32'hFFFFFFFD, -1, "ch3_after_race");
        wr_reg(0, B0 + 32'h38, 32'h4);
        rd_reg(0, G0, 32'h0, 0, "status_all_clear");

        // Prescaler on channel 1
`ifdef TIMER_BANK_PRESCALER_EN
        wr_reg(0, G0 + 32'h4, 32'h3);
        wr_reg(0, B0 + 32'h18, 32'h1);
        rd_reg(0, G0 + 32'h4, 32'h3, -1, "prescale_readback");
        rd_reg(0, B0 + 32'h14, 32'h0, -1, "pre_tl0_a");
        rd_reg(0, B0 + 32'h14, 32'h0, -1, "pre_tl0_b");
        rd_reg(0, B0 + 32'h14, 32'h1, -1, "pre_tl1");
        idle(3);
        rd_reg(0, B0 + 32'h14, 32'h2, -1, "pre_tl2");
`else
        wr_reg(0, G0 + 32'h4, 32'h3);
        wr_reg(0, B0 + 32'h18, 32'h1);
        rd_reg(0, G0 + 32'h4, 32'h0, -1, "prescale_absent");
        idle(7);
        rd_reg(0, B0 + 32'h14, 32'h8, -1, "noprescale_tl8");
`endif

        // Narrow counter and small-bank decode
        wr_reg(1, B1 + 32'h04, 32'hABCDEFFE);
        wr_reg(1, B1 + 32'h08, 32'h1);
        rd_reg(1, B1 + 32'h04, 32'h000000FE, 0, "w8_tl_fe");
        rd_reg(1, B1 + 32'h04, 32'h000000FF, 0, "w8_tl_ff");
        rd_reg(1, B1 + 32'h04, 32'h00000000, 0, "w8_wrap");
        rd_reg(1, B1 + 32'h08, 32'h1, -1, "w8_tcon");
        rd_reg(1, B1 + 32'h28, 32'h0, -1, "w8_unmapped");
        rd_reg(1, G1, 32'h0, -1, "w8_status");

        // Reset mid-count
        wr_reg(0, B0 + 32'h24, 32'hFFFFFFFF);
        wr_reg(0, B0 + 32'h28, 32'h3);
        rd_reg(0, B0 + 32'h28, 32'h3, 0, "pre_reset_tcon");
        rd_reg(0, B0 + 32'h28, 32'h7, 1, "pre_reset_pend");
        reset = 1'b0;
        rd_reg(0, B0 + 32'h28, 32'h0, 0, "midreset_tcon2");
        rd_reg(0, B0 + 32'h14, 32'h0, 0, "midreset_tl1");
        rd_reg(0, B0 + 32'h20, 32'h0, 0, "midreset_th2");
        rd_reg(1, B1 + 32'h08, 32'h0, 0, "midreset_w8_tcon");
        idle(3);
        rd_reg(0, B0 + 32'h14, 32'h0, 0, "reset_hold_tl1");
        reset = 1'b1;
        rd_reg(0, B0 + 32'h14, 32'h0, 0, "post_release_tl1");
        idle(2);
        rd_reg(0, B0 + 32'h14, 32'h0, 0, "post_release_idle");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
